xmtr: RTL and testbench

//  Serial frame transmitter; the sending end of the rcvr link. Accepts a byte

---
 rtl/xmtr.sv | 129 ++++++++++++
 tb/tb_xmtr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/xmtr.sv
// Serial frame transmitter: one-entry holding register feeding a MATCH header + 8 body bits, MSB first.
// Optional even-parity trailer bit when XMTR_PARITY_EN is defined.
module xmtr #(
  parameter logic [7:0] MATCH    = 8'hA5,
  parameter logic       IDLE_BIT = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       writing,
  output logic       data_out,
  output logic       busy,
  output logic       full,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY
`ifdef XMTR_PARITY_EN
    , PAR
`endif
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] cnt;
  logic [2:0] next_cnt;
  logic [7:0] holding;
  logic [7:0] shift;
  logic [7:0] next_shift;
  logic       next_line;
  logic       last_bit;
  logic       load;
  logic       accept;
  logic       reject;

`ifdef XMTR_PARITY_EN
  assign last_bit = (state == PAR);
`else
  assign last_bit = (state == BODY) && (cnt == 3'd7);
`endif

  // A pending byte starts its header right after the last bit, so frames abut with no gap.
  assign load       = full && ((state == IDLE) || last_bit);
  assign accept     = writing && (!full || load);
  assign reject     = writing && full && !load;
  assign next_shift = load ? holding : shift;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (load) begin
      next_state = HEAD;
      next_cnt   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          next_state = IDLE;
        end
        HEAD: begin
          next_cnt = cnt + 3'd1;
          if (cnt == 3'd7) next_state = BODY;
        end
        BODY: begin
          next_cnt = cnt + 3'd1;
          if (cnt == 3'd7) begin
`ifdef XMTR_PARITY_EN
            next_state = PAR;
`else
            next_state = IDLE;
`endif
          end
        end
`ifdef XMTR_PARITY_EN
        PAR: begin
          next_state = IDLE;
          next_cnt   = 3'd0;
        end
`endif
        default: begin
          next_state = IDLE;
          next_cnt   = 3'd0;
        end
      endcase
    end
  end

  // The line is registered, so it is decoded from the state being entered; ~cnt selects bit 7-cnt.
  always_comb begin
    next_line = IDLE_BIT;
    case (next_state)
      HEAD:    next_line = MATCH[~next_cnt];
      BODY:    next_line = next_shift[~next_cnt];
`ifdef XMTR_PARITY_EN
      PAR:     next_line = ^next_shift;
`endif
      default: next_line = IDLE_BIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      data_out <= IDLE_BIT;
      busy     <= 1'b0;
      full     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      data_out <= next_line;
      busy     <= (next_state != IDLE);
      if (accept)    full <= 1'b1;
      else if (load) full <= 1'b0;
      if (accept)      overrun <= 1'b0;
      else if (reject) overrun <= 1'b1;
    end
  end

  // Data registers carry no reset; full gates every use of holding.
  always_ff @(posedge clock) begin
    if (load)   shift   <= holding;
    if (accept) holding <= data_in;
  end

endmodule

// File: tb/tb_xmtr.sv
// Directed self-checking bench for xmtr (default build, 16-bit frames).
module tb_xmtr;

  logic       clock;
  logic       reset_n;
  logic [7:0] data_in;
  logic       writing;
  logic       data_out;
  logic       busy;
  logic       full;
  logic       overrun;

  int total;
  int bad;

  logic [15:0] frame16;
  logic [31:0] frame32;
  logic [47:0] frame48;
  logic [15:0] captured;

  xmtr dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .data_in  (data_in),
    .writing  (writing),
    .data_out (data_out),
    .busy     (busy),
    .full     (full),
    .overrun  (overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] value);
    data_in = value;
    writing = 1'b1;
    step;
    writing = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_data_out"}, 16'(data_out), 16'd0);
    checkOutput({tag, "_busy"}, 16'(busy), 16'd0);
    checkOutput({tag, "_full"}, 16'(full), 16'd0);
    checkOutput({tag, "_overrun"}, 16'(overrun), 16'd0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    writing = 1'b0;
    data_in = 8'h00;

    // Test 1: reset values, then 20 idle cycles
    #3;
    checkIdle("t1_in_reset");
    #19 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) step;
    checkIdle("t1_idle");

    // Test 2: single frame 3C, serial A5 3C on E1..E16
    frame16  = 16'hA53C;
    captured = 16'h0000;
    applyStimulus(8'h3C);
    checkOutput("t2_full_e0", 16'(full), 16'd1);
    checkOutput("t2_busy_e0", 16'(busy), 16'd0);
    for (int k = 1; k <= 16; k++) begin
      step;
      captured = {captured[14:0], data_out};
      checkOutput("t2_bit", 16'(data_out), 16'(frame16[16-k]));
      checkOutput("t2_busy", 16'(busy), 16'd1);
    end
    checkOutput("t2_loopback", captured, 16'hA53C);
    checkOutput("t2_full_end", 16'(full), 16'd0);
    step;
    checkIdle("t2_after");

    // Test 3: back-to-back 81 then 7E
    frame32 = 32'hA581A57E;
    applyStimulus(8'h81);
    step;
    checkOutput("t3_bit_e1", 16'(data_out), 16'(frame32[31]));
    applyStimulus(8'h7E);
    checkOutput("t3_bit_e2", 16'(data_out), 16'(frame32[30]));
    checkOutput("t3_full_e2", 16'(full), 16'd1);
    for (int k = 3; k <= 32; k++) begin
      step;
      checkOutput("t3_bit", 16'(data_out), 16'(frame32[32-k]));
      checkOutput("t3_busy", 16'(busy), 16'd1);
    end
    step;
    checkIdle("t3_after");

    // Test 4: third write while full is dropped and sets overrun
    frame32 = 32'hA512A534;
    applyStimulus(8'h12);
    step;
    checkOutput("t4_bit_e1", 16'(data_out), 16'(frame32[31]));
    applyStimulus(8'h34);
    checkOutput("t4_bit_e2", 16'(data_out), 16'(frame32[30]));
    applyStimulus(8'h56);
    checkOutput("t4_bit_e3", 16'(data_out), 16'(frame32[29]));
    checkOutput("t4_overrun_set", 16'(overrun), 16'd1);
    checkOutput("t4_full_e3", 16'(full), 16'd1);
    for (int k = 4; k <= 32; k++) begin
      step;
      checkOutput("t4_bit", 16'(data_out), 16'(frame32[32-k]));
    end
    step;
    checkOutput("t4_busy_end", 16'(busy), 16'd0);
    checkOutput("t4_full_end", 16'(full), 16'd0);
    checkOutput("t4_overrun_sticky", 16'(overrun), 16'd1);

    // Test 5: accepted write clears overrun; write coinciding with a last-bit load
    frame48 = 48'hA599_A542_A55A;
    applyStimulus(8'h99);
    checkOutput("t5_overrun_clear", 16'(overrun), 16'd0);
    for (int k = 1; k <= 48; k++) begin
      writing = (k == 2) || (k == 17);
      data_in = (k == 2) ? 8'h42 : 8'h5A;
      step;
      writing = 1'b0;
      checkOutput("t5_bit", 16'(data_out), 16'(frame48[48-k]));
      checkOutput("t5_busy", 16'(busy), 16'd1);
      if (k == 17) begin
        checkOutput("t5_full_at_load", 16'(full), 16'd1);
        checkOutput("t5_overrun_at_load", 16'(overrun), 16'd0);
      end
    end
    step;
    checkIdle("t5_after");

    // Test 6: reset at BODY cnt 3 aborts the frame; a fresh frame follows
    applyStimulus(8'hC3);
    for (int k = 1; k <= 12; k++) step;
    checkOutput("t6_busy_mid", 16'(busy), 16'd1);
    #2 reset_n = 1'b0;
    #1;
    checkIdle("t6_async_reset");
    #1 reset_n = 1'b1;
    step;
    checkIdle("t6_released");
    frame16 = 16'hA5E7;
    applyStimulus(8'hE7);
    for (int k = 1; k <= 16; k++) begin
      step;
      checkOutput("t6_bit", 16'(data_out), 16'(frame16[16-k]));
    end
    step;
    checkIdle("t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
